jk_cmd_sequencer: RTL and testbench

- Upstream driver for the JK storage stage.
- Accepts hold/reset/set/toggle commands over a valid/ready handshake and buffers them in a small FIFO.
- Plays each command onto registered J/K outputs for a fixed drive window, followed by a quiet gap.
- Keeps a shadow model of the expected Q, compares it against the Q fed back from the storage stage, and flags any disagreement.

---
 rtl/jk_cmd_sequencer.sv | 145 ++++++++++++++
 tb/tb_jk_cmd_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_sequencer.sv
// rtl/jk_cmd_sequencer.sv - JK command FIFO, drive sequencer and shadow-Q checker
module jk_cmd_sequencer #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic       J,
    output logic       K,
    input  logic       q_fb,
    input  logic       mismatch_clr,
    output logic       exp_q,
    output logic       mismatch,
    output logic       busy,
    output logic [7:0] cmd_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = 16;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

    state_t        state_q;
    logic [1:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          ready_q;
    logic [1:0]    op_q;
    logic [CW-1:0] cnt_q;
    logic          j_q, k_q, shadow_q, mismatch_q;
    logic [7:0]    cmd_count_q;

    logic          push, pop, gap_last, shadow_d;
    logic [1:0]    head_op;
    logic [CW-1:0] win_last;

    // ready_q keeps cmd_ready low while reset is held and releases on the first edge after
    assign cmd_ready = ready_q & (count_q != (AW+1)'(DEPTH));
    assign push      = cmd_valid & cmd_ready;
    assign head_op   = mem_q[rd_ptr_q];
    assign gap_last  = (state_q == S_GAP) && (cnt_q == '0);
    assign pop       = (count_q != '0) && ((state_q == S_IDLE) || gap_last);
    // Toggle is single-shot so the storage stage flips exactly once
    assign win_last  = (head_op == 2'b11) ? '0 : HOLD_LAST;

    always_comb begin
        shadow_d = shadow_q;
        case (op_q)
            2'b01:   shadow_d = 1'b0;
            2'b10:   shadow_d = 1'b1;
            2'b11:   shadow_d = ~shadow_q;
            default: shadow_d = shadow_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= cmd_op;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            ready_q <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            j_q         <= 1'b0;
            k_q         <= 1'b0;
            op_q        <= 2'b00;
            cnt_q       <= '0;
            shadow_q    <= 1'b0;
            mismatch_q  <= 1'b0;
            cmd_count_q <= 8'd0;
        end else begin
            if (mismatch_clr) mismatch_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        {j_q, k_q} <= head_op;
                        op_q       <= head_op;
                        cnt_q      <= win_last;
                        state_q    <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (cnt_q == '0) begin
                        j_q         <= 1'b0;
                        k_q         <= 1'b0;
                        shadow_q    <= shadow_d;
                        cmd_count_q <= cmd_count_q + 8'd1;
                        cnt_q       <= GAP_LAST;
                        state_q     <= S_GAP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_GAP: begin
                    // Later assignment lets a compare failure override a same-edge clear
                    if ((cnt_q == GAP_LAST) && (q_fb != shadow_q)) mismatch_q <= 1'b1;
                    if (cnt_q == '0) begin
                        if (pop) begin
                            {j_q, k_q} <= head_op;
                            op_q       <= head_op;
                            cnt_q      <= win_last;
                            state_q    <= S_DRIVE;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign J         = j_q;
    assign K         = k_q;
    assign exp_q     = shadow_q;
    assign mismatch  = mismatch_q;
    assign cmd_count = cmd_count_q;
    assign busy      = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb/tb_jk_cmd_sequencer.sv - scoreboard bench for jk_cmd_sequencer
module tb_jk_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, cmd_valid, mismatch_clr, fault;
    logic [1:0] cmd_op;
    logic       q_fb, cmd_ready, J, K, exp_q, mismatch, busy;
    logic [7:0] cmd_count;
    logic       stage_q;

    jk_cmd_sequencer #(.DEPTH(4), .HOLD_CYCLES(2), .GAP_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_ready(cmd_ready), .J(J), .K(K), .q_fb(q_fb),
        .mismatch_clr(mismatch_clr), .exp_q(exp_q), .mismatch(mismatch),
        .busy(busy), .cmd_count(cmd_count)
    );

    always #5 clk = ~clk;

    // Behavioural JK storage stage feeding q_fb; fault forces a stuck-at-0 return
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_q <= 1'b0;
        else case ({J, K})
            2'b01:   stage_q <= 1'b0;
            2'b10:   stage_q <= 1'b1;
            2'b11:   stage_q <= ~stage_q;
            default: stage_q <= stage_q;
        endcase
    end
    assign q_fb = fault ? 1'b0 : stage_q;

    typedef struct {
        logic [1:0] jk;
        int         run;
        logic       q;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    logic mq;
    bit   last_stalled;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input logic [1:0] op);
        exp_t e;
        int guard;
        last_stalled = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = op;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            last_stalled = 1'b1;
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            check("push_timeout", 0, 1);
            return;
        end
        @(posedge clk);
        #1;
        case (op)
            2'b01:   mq = 1'b0;
            2'b10:   mq = 1'b1;
            2'b11:   mq = ~mq;
            default: mq = mq;
        endcase
        e.jk = op;
        e.run = (op == 2'b00) ? 0 : (op == 2'b11) ? 1 : 2;
        e.q = mq;
        sb.push_back(e);
    endtask

    task automatic drain();
        int guard;
        cmd_valid = 1'b0;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain_timeout", busy, 0);
    endtask

    // Monitor: each cmd_count step retires one op from the scoreboard
    int         mon_run = 0;
    logic [1:0] mon_seen = 2'b00;
    logic [7:0] mon_prev = 8'd0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            mon_run = 0;
            mon_seen = 2'b00;
            mon_prev = 8'd0;
        end else if (cmd_count != mon_prev) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_op", 1, 0);
            end else begin
                e = sb.pop_front();
                check("op_jk", mon_seen, e.jk);
                check("op_run", mon_run, e.run);
                check("op_exp_q", exp_q, e.q);
                check("op_gap_jk", {J, K}, 0);
            end
            mon_run = 0;
            mon_seen = 2'b00;
            mon_prev = cmd_count;
        end else if (J || K) begin
            mon_run++;
            mon_seen = {J, K};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] ops [8];
        bit any_stall;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00;
        mismatch_clr = 1'b0; fault = 1'b0; mq = 1'b0;
        ops = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b10, 2'b01, 2'b11, 2'b00};

        repeat (2) @(negedge clk);
        check("rst_jk", {J, K}, 0);
        check("rst_ready", cmd_ready, 0);
        check("rst_cnt", cmd_count, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", cmd_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_expq", exp_q, 0);
        check("idle_mismatch", mismatch, 0);

        // Single set: latency and window
        push(2'b10);
        cmd_valid = 1'b0;
        @(negedge clk); check("set_no_bypass", {J, K}, 0);
        @(negedge clk); check("set_drive1", {J, K}, 2);
        @(negedge clk); check("set_drive2", {J, K}, 2);
        @(negedge clk);
        check("set_end_jk", {J, K}, 0);
        check("set_expq", exp_q, 1);
        check("set_cnt", cmd_count, 1);
        check("set_gap_busy", busy, 1);
        @(negedge clk);
        check("set_mismatch", mismatch, 0);
        check("set_idle_busy", busy, 0);

        // Back-to-back toggles: 1 -> 0 -> 1
        push(2'b11);
        push(2'b11);
        drain();
        check("tog_cnt", cmd_count, 3);
        check("tog_expq", exp_q, 1);

        // Continuous valid overruns the FIFO
        any_stall = 1'b0;
        foreach (ops[i]) begin
            push(ops[i]);
            any_stall |= last_stalled;
        end
        drain();
        check("full_stall_seen", any_stall, 1);
        check("full_cnt", cmd_count, 11);
        check("full_expq", exp_q, 1);

        // Mismatch: sticky across a clean op, then cleared
        fault = 1'b1;
        push(2'b10);
        drain();
        check("mm_set", mismatch, 1);
        fault = 1'b0;
        push(2'b01);
        drain();
        check("mm_sticky", mismatch, 1);
        mismatch_clr = 1'b1;
        @(negedge clk);
        mismatch_clr = 1'b0;
        check("mm_cleared", mismatch, 0);

        // Compare failure beats a same-edge clear
        fault = 1'b1;
        push(2'b10);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        mismatch_clr = 1'b1;
        @(negedge clk);
        mismatch_clr = 1'b0;
        check("mm_set_wins", mismatch, 1);
        fault = 1'b0;
        drain();
        mismatch_clr = 1'b1;
        @(negedge clk);
        mismatch_clr = 1'b0;
        check("mm_cleared2", mismatch, 0);
        check("pre_rst_cnt", cmd_count, 14);

        // Reset mid-drive with two queued
        push(2'b10);
        push(2'b01);
        push(2'b10);
        cmd_valid = 1'b0;
        check("mid_drive_j", {J, K}, 2);
        #1 rst_n = 1'b0;
        #1;
        check("abort_jk", {J, K}, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", cmd_ready, 0);
        sb.delete();
        mq = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", cmd_ready, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_cnt", cmd_count, 0);
        check("post_rst_expq", exp_q, 0);
        check("post_rst_jk", {J, K}, 0);

        push(2'b11);
        drain();
        check("final_expq", exp_q, 1);
        check("final_cnt", cmd_count, 1);
        check("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
